// File: rtl/hex_counter_display.sv
// 6-digit BCD up/down event counter driven by a PIO control word, shown on six active-low 7-segment displays.
// Latency: ctrl sampled at E0 -> counter at E1 -> hex at E2; no backpressure, outputs free-running.
module hex_counter_display #(
  parameter int unsigned TICK_BASE = 50000000,
  parameter bit          BLANK_LZ  = 1'b0
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [5:0] displays_ctrl,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4,
  output logic [6:0] hex5,
  output logic       tick,
  output logic       wrap
);

  localparam logic [6:0] SEG_ZERO  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] HEX_RST_HI = BLANK_LZ ? SEG_BLANK : SEG_ZERO;

  logic [5:0]       ctrl_q, ctrl_q2;
  logic [31:0]      presc_q, presc_d;
  logic [5:0][3:0]  digits_q, digits_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic [5:0][6:0]  hex_q, hex_d;

  logic             clr_edge;
  logic             rate_chg;
  logic             step;
  logic [31:0]      period;
  logic             carry;
  logic             zero_above;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign clr_edge = ctrl_q[2] & ~ctrl_q2[2];
  assign rate_chg = (ctrl_q[5:3] != ctrl_q2[5:3]);

  // Fast rates on a small TICK_BASE shift to zero; clamp so the counter still steps every cycle.
  always_comb begin
    period = 32'(TICK_BASE) >> ctrl_q[5:3];
    if (period == 32'd0) begin
      period = 32'd1;
    end
  end

  always_comb begin
    presc_d = presc_q + 32'd1;
    step    = 1'b0;
    if (!ctrl_q[0] || rate_chg || clr_edge) begin
      presc_d = 32'd0;
    end else if (presc_q == period - 32'd1) begin
      presc_d = 32'd0;
      step    = 1'b1;
    end
  end

  always_comb begin
    digits_d = digits_q;
    tick_d   = 1'b0;
    wrap_d   = 1'b0;
    carry    = 1'b0;
    if (clr_edge) begin
      digits_d = '0;
    end else if (step) begin
      tick_d = 1'b1;
      carry  = 1'b1;
      for (int i = 0; i < 6; i++) begin
        if (carry) begin
          if (!ctrl_q[1]) begin
            if (digits_q[i] == 4'd9) begin
              digits_d[i] = 4'd0;
            end else begin
              digits_d[i] = digits_q[i] + 4'd1;
              carry       = 1'b0;
            end
          end else begin
            if (digits_q[i] == 4'd0) begin
              digits_d[i] = 4'd9;
            end else begin
              digits_d[i] = digits_q[i] - 4'd1;
              carry       = 1'b0;
            end
          end
        end
      end
      wrap_d = carry;
    end
  end

  // Scan from the most significant digit so each position knows whether everything above it is zero.
  always_comb begin
    hex_d      = '0;
    zero_above = 1'b1;
    for (int k = 5; k >= 0; k--) begin
      zero_above = zero_above & (digits_q[k] == 4'd0);
      if (BLANK_LZ && (k != 0) && zero_above) begin
        hex_d[k] = SEG_BLANK;
      end else begin
        hex_d[k] = seg7(digits_q[k]);
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ctrl_q   <= '0;
      ctrl_q2  <= '0;
      presc_q  <= '0;
      digits_q <= '0;
      tick_q   <= 1'b0;
      wrap_q   <= 1'b0;
      hex_q[0] <= SEG_ZERO;
      for (int k = 1; k < 6; k++) begin
        hex_q[k] <= HEX_RST_HI;
      end
    end else begin
      ctrl_q   <= displays_ctrl;
      ctrl_q2  <= ctrl_q;
      presc_q  <= presc_d;
      digits_q <= digits_d;
      tick_q   <= tick_d;
      wrap_q   <= wrap_d;
      hex_q    <= hex_d;
    end
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];
  assign tick = tick_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_hex_counter_display.sv
// Directed bench for hex_counter_display: two instances (BLANK_LZ 0 and 1) share clock, reset and control.
`timescale 1ns/1ps
module tb_hex_counter_display;

  logic       clk_clk = 1'b0;
  logic       reset_reset_n;
  logic [5:0] displays_ctrl;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic       tick, wrap;
  logic [6:0] hb0, hb1, hb2, hb3, hb4, hb5;
  logic       tick_b, wrap_b;
  int         total = 0;
  int         bad = 0;
  int         n;

  always #5 clk_clk = ~clk_clk;

  hex_counter_display #(.TICK_BASE(8), .BLANK_LZ(1'b0)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .displays_ctrl(displays_ctrl),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
    .tick(tick), .wrap(wrap)
  );

  hex_counter_display #(.TICK_BASE(8), .BLANK_LZ(1'b1)) dut_b (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .displays_ctrl(displays_ctrl),
    .hex0(hb0), .hex1(hb1), .hex2(hb2), .hex3(hb3), .hex4(hb4), .hex5(hb5),
    .tick(tick_b), .wrap(wrap_b)
  );

  task automatic step_edge();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic do_reset();
    reset_reset_n = 1'b0;
    displays_ctrl = 6'b000_000;
    step_edge();
    step_edge();
    reset_reset_n = 1'b1;
  endtask

  task automatic settle(input logic [5:0] base);
    displays_ctrl = base;
    repeat (3) step_edge();
  endtask

  // Rate 3 gives period 1; asserting run for one sampled cycle yields exactly one step.
  task automatic single_step(input logic [5:0] base);
    displays_ctrl = base | 6'b000_001;
    step_edge();
    displays_ctrl = base;
    step_edge();
  endtask

  task automatic wait_tick(input int max, output int cnt);
    cnt = 0;
    do begin
      step_edge();
      cnt++;
    end while (tick !== 1'b1 && cnt < max);
  endtask

  task automatic test_reset();
    reset_reset_n = 1'b0;
    displays_ctrl = 6'b000_000;
    step_edge();
    step_edge();
    total++; if (hex0 !== 7'h40) begin bad++; $display("FAIL rst_hex0 got=%h exp=%h", hex0, 7'h40); end
    total++; if (hex3 !== 7'h40) begin bad++; $display("FAIL rst_hex3 got=%h exp=%h", hex3, 7'h40); end
    total++; if (hex5 !== 7'h40) begin bad++; $display("FAIL rst_hex5 got=%h exp=%h", hex5, 7'h40); end
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL rst_tick got=%b exp=0", tick); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL rst_wrap got=%b exp=0", wrap); end
    total++; if (hb0 !== 7'h40) begin bad++; $display("FAIL rst_blank_hex0 got=%h exp=%h", hb0, 7'h40); end
    total++; if (hb1 !== 7'h7F) begin bad++; $display("FAIL rst_blank_hex1 got=%h exp=%h", hb1, 7'h7F); end
    total++; if (hb5 !== 7'h7F) begin bad++; $display("FAIL rst_blank_hex5 got=%h exp=%h", hb5, 7'h7F); end
    reset_reset_n = 1'b1;
    step_edge();
    step_edge();
    total++; if (hex0 !== 7'h40) begin bad++; $display("FAIL idle_hex0 got=%h exp=%h", hex0, 7'h40); end
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL idle_tick got=%b exp=0", tick); end
  endtask

  task automatic test_count_up();
    displays_ctrl = 6'b000_001;
    wait_tick(20, n);
    total++; if (n !== 9) begin bad++; $display("FAIL first_tick_latency got=%0d exp=9", n); end
    for (int i = 1; i < 12; i++) begin
      wait_tick(20, n);
      total++; if (n !== 8) begin bad++; $display("FAIL tick_period[%0d] got=%0d exp=8", i, n); end
    end
    displays_ctrl = 6'b000_000;
    step_edge();
    total++; if (hex0 !== 7'h24) begin bad++; $display("FAIL cnt12_hex0 got=%h exp=%h", hex0, 7'h24); end
    total++; if (hex1 !== 7'h79) begin bad++; $display("FAIL cnt12_hex1 got=%h exp=%h", hex1, 7'h79); end
    total++; if (hex2 !== 7'h40) begin bad++; $display("FAIL cnt12_hex2 got=%h exp=%h", hex2, 7'h40); end
    total++; if (hex5 !== 7'h40) begin bad++; $display("FAIL cnt12_hex5 got=%h exp=%h", hex5, 7'h40); end
  endtask

  task automatic test_wrap();
    do_reset();
    settle(6'b011_010);
    single_step(6'b011_010);
    total++; if (tick !== 1'b1) begin bad++; $display("FAIL down_wrap_tick got=%b exp=1", tick); end
    total++; if (wrap !== 1'b1) begin bad++; $display("FAIL down_wrap got=%b exp=1", wrap); end
    total++; if (wrap_b !== 1'b1) begin bad++; $display("FAIL down_wrap_b got=%b exp=1", wrap_b); end
    step_edge();
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL wrap_one_cycle got=%b exp=0", wrap); end
    total++; if (hex0 !== 7'h10) begin bad++; $display("FAIL nines_hex0 got=%h exp=%h", hex0, 7'h10); end
    total++; if (hex5 !== 7'h10) begin bad++; $display("FAIL nines_hex5 got=%h exp=%h", hex5, 7'h10); end
    total++; if (hb5 !== 7'h10) begin bad++; $display("FAIL nines_blank_hex5 got=%h exp=%h", hb5, 7'h10); end
    single_step(6'b011_000);
    total++; if (wrap !== 1'b1) begin bad++; $display("FAIL up_wrap got=%b exp=1", wrap); end
    step_edge();
    total++; if (hex0 !== 7'h40) begin bad++; $display("FAIL upwrap_hex0 got=%h exp=%h", hex0, 7'h40); end
    total++; if (hex3 !== 7'h40) begin bad++; $display("FAIL upwrap_hex3 got=%h exp=%h", hex3, 7'h40); end
    total++; if (hex5 !== 7'h40) begin bad++; $display("FAIL upwrap_hex5 got=%h exp=%h", hex5, 7'h40); end
    total++; if (hb5 !== 7'h7F) begin bad++; $display("FAIL upwrap_blank_hex5 got=%h exp=%h", hb5, 7'h7F); end
    single_step(6'b011_000);
    total++; if (tick !== 1'b1) begin bad++; $display("FAIL plain_step_tick got=%b exp=1", tick); end
    total++; if (tick_b !== 1'b1) begin bad++; $display("FAIL plain_step_tick_b got=%b exp=1", tick_b); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL plain_step_wrap got=%b exp=0", wrap); end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 40; i++) single_step(6'b011_000);
    step_edge();
    total++; if (hex1 !== 7'h19) begin bad++; $display("FAIL cnt41_hex1 got=%h exp=%h", hex1, 7'h19); end
    total++; if (hex0 !== 7'h79) begin bad++; $display("FAIL cnt41_hex0 got=%h exp=%h", hex0, 7'h79); end
    displays_ctrl = 6'b011_101;
    step_edge();
    displays_ctrl = 6'b011_100;
    step_edge();
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL clear_tick got=%b exp=0", tick); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL clear_wrap got=%b exp=0", wrap); end
    step_edge();
    total++; if (hex0 !== 7'h40) begin bad++; $display("FAIL clear_hex0 got=%h exp=%h", hex0, 7'h40); end
    total++; if (hex1 !== 7'h40) begin bad++; $display("FAIL clear_hex1 got=%h exp=%h", hex1, 7'h40); end
    total++; if (hb1 !== 7'h7F) begin bad++; $display("FAIL clear_blank_hex1 got=%h exp=%h", hb1, 7'h7F); end
    repeat (20) step_edge();
    total++; if (hex0 !== 7'h40) begin bad++; $display("FAIL clear_hold_hex0 got=%h exp=%h", hex0, 7'h40); end
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL clear_hold_tick got=%b exp=0", tick); end
    single_step(6'b011_100);
    total++; if (tick !== 1'b1) begin bad++; $display("FAIL clear_held_step_tick got=%b exp=1", tick); end
    step_edge();
    total++; if (hex0 !== 7'h79) begin bad++; $display("FAIL clear_held_count got=%h exp=%h", hex0, 7'h79); end
  endtask

  task automatic test_rate_change();
    do_reset();
    displays_ctrl = 6'b000_001;
    repeat (6) step_edge();
    displays_ctrl = 6'b001_001;
    wait_tick(20, n);
    total++; if (n !== 6) begin bad++; $display("FAIL rate_restart_latency got=%0d exp=6", n); end
    wait_tick(20, n);
    total++; if (n !== 4) begin bad++; $display("FAIL rate1_period got=%0d exp=4", n); end
  endtask

  task automatic test_blank();
    do_reset();
    settle(6'b011_000);
    for (int i = 0; i < 305; i++) single_step(6'b011_000);
    step_edge();
    total++; if (hb5 !== 7'h7F) begin bad++; $display("FAIL b305_hex5 got=%h exp=%h", hb5, 7'h7F); end
    total++; if (hb4 !== 7'h7F) begin bad++; $display("FAIL b305_hex4 got=%h exp=%h", hb4, 7'h7F); end
    total++; if (hb3 !== 7'h7F) begin bad++; $display("FAIL b305_hex3 got=%h exp=%h", hb3, 7'h7F); end
    total++; if (hb2 !== 7'h30) begin bad++; $display("FAIL b305_hex2 got=%h exp=%h", hb2, 7'h30); end
    total++; if (hb1 !== 7'h40) begin bad++; $display("FAIL b305_hex1 got=%h exp=%h", hb1, 7'h40); end
    total++; if (hb0 !== 7'h12) begin bad++; $display("FAIL b305_hex0 got=%h exp=%h", hb0, 7'h12); end
    total++; if (hex5 !== 7'h40) begin bad++; $display("FAIL nb305_hex5 got=%h exp=%h", hex5, 7'h40); end
    total++; if (hex2 !== 7'h30) begin bad++; $display("FAIL nb305_hex2 got=%h exp=%h", hex2, 7'h30); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 472; i++) single_step(6'b011_000);
    step_edge();
    total++; if (hex0 !== 7'h78) begin bad++; $display("FAIL c777_hex0 got=%h exp=%h", hex0, 7'h78); end
    total++; if (hex2 !== 7'h78) begin bad++; $display("FAIL c777_hex2 got=%h exp=%h", hex2, 7'h78); end
    total++; if (hb3 !== 7'h7F) begin bad++; $display("FAIL c777_blank_hex3 got=%h exp=%h", hb3, 7'h7F); end
    displays_ctrl = 6'b000_001;
    repeat (3) step_edge();
    #3;
    reset_reset_n = 1'b0;
    #1;
    total++; if (hex0 !== 7'h40) begin bad++; $display("FAIL arst_hex0 got=%h exp=%h", hex0, 7'h40); end
    total++; if (hex2 !== 7'h40) begin bad++; $display("FAIL arst_hex2 got=%h exp=%h", hex2, 7'h40); end
    total++; if (hb2 !== 7'h7F) begin bad++; $display("FAIL arst_blank_hex2 got=%h exp=%h", hb2, 7'h7F); end
    total++; if (hb0 !== 7'h40) begin bad++; $display("FAIL arst_blank_hex0 got=%h exp=%h", hb0, 7'h40); end
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL arst_tick got=%b exp=0", tick); end
    step_edge();
    reset_reset_n = 1'b1;
    wait_tick(20, n);
    total++; if (n !== 9) begin bad++; $display("FAIL post_arst_latency got=%0d exp=9", n); end
    step_edge();
    total++; if (hex0 !== 7'h79) begin bad++; $display("FAIL post_arst_hex0 got=%h exp=%h", hex0, 7'h79); end
    total++; if (hex2 !== 7'h40) begin bad++; $display("FAIL post_arst_hex2 got=%h exp=%h", hex2, 7'h40); end
  endtask

  initial begin
    reset_reset_n = 1'b0;
    displays_ctrl = 6'b000_000;
    test_reset();
    test_count_up();
    test_wrap();
    test_clear();
    test_rate_change();
    test_blank();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
